iir_biquad_sequencer: RTL



---
 rtl/iir_biquad_sequencer_if.sv | 23 ++
 rtl/iir_biquad_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/iir_biquad_sequencer_if.sv
// Sample/coefficient/result bundle between the biquad sequencer (slave) and
// its surroundings: sample source, coefficient selector, output formatter (master).
interface iir_biquad_sequencer_if #(
  parameter int W = 25
);
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic [W-1:0] coef_in;
  logic [2:0]   coef_sel;
  logic [W-1:0] y_out;
  logic         y_valid;
  logic         busy;

  modport master (
    output sample_in, sample_valid, coef_in,
    input  coef_sel, y_out, y_valid, busy
  );

  modport slave (
    input  sample_in, sample_valid, coef_in,
    output coef_sel, y_out, y_valid, busy
  );
endinterface

// File: rtl/iir_biquad_sequencer.sv
// Time-multiplexed biquad: one shared multiplier, five MAC cycles per sample.
// Optional macro IIR_ROUNDING_EN: round half up instead of floor before saturation.
module iir_biquad_sequencer #(
  parameter int W     = 25,
  parameter int FRAC  = 14,
  parameter int ACC_W = 54
) (
  input  logic                 clk,
  input  logic                 reset,
  iir_biquad_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t                   state_reg, state_next;
  logic [2:0]               step_reg, step_next;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [W-1:0]      x0_reg, x1_reg, x2_reg, y1_reg, y2_reg;
  logic signed [W-1:0]      y_out_reg;
  logic                     y_valid_reg;

  logic [2:0]               coef_sel;
  logic signed [W-1:0]      operand;
  logic                     subtract;
  logic signed [2*W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_bias;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [W-1:0]      sat_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  // Next state plus the per-step coefficient select and operand routing.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    coef_sel   = 3'b111;
    operand    = '0;
    subtract   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.sample_valid) begin
          state_next = MAC;
          step_next  = '0;
        end
      end
      MAC: begin
        step_next = step_reg + 3'd1;
        case (step_reg)
          3'd0:    begin coef_sel = 3'b010; operand = x0_reg; end
          3'd1:    begin coef_sel = 3'b011; operand = x1_reg; end
          3'd2:    begin coef_sel = 3'b100; operand = x2_reg; end
          3'd3:    begin coef_sel = 3'b000; operand = y1_reg; subtract = 1'b1; end
          default: begin coef_sel = 3'b001; operand = y2_reg; subtract = 1'b1; end
        endcase
        if (step_reg == 3'd4) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod     = $signed(bus.coef_in) * operand;
    prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    acc_sum  = subtract ? (acc_reg - prod_ext) : (acc_reg + prod_ext);
`ifdef IIR_ROUNDING_EN
    acc_bias = acc_reg + (ACC_W'(1) << (FRAC-1));
`else
    acc_bias = acc_reg;
`endif
    shifted = acc_bias >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[W-1:0];
    else                        sat_val = shifted[W-1:0];
  end

  // Datapath: history only advances in FIN, so a reset mid-flight leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg     <= '0;
      x0_reg      <= '0;
      x1_reg      <= '0;
      x2_reg      <= '0;
      y1_reg      <= '0;
      y2_reg      <= '0;
      y_out_reg   <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      y_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.sample_valid) begin
            x0_reg  <= bus.sample_in;
            acc_reg <= '0;
          end
        end
        MAC: acc_reg <= acc_sum;
        FIN: begin
          y_out_reg   <= sat_val;
          y_valid_reg <= 1'b1;
          x2_reg      <= x1_reg;
          x1_reg      <= x0_reg;
          y2_reg      <= y1_reg;
          y1_reg      <= sat_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.coef_sel = coef_sel;
  assign bus.y_out    = y_out_reg;
  assign bus.y_valid  = y_valid_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule
